exec_unit: RTL and testbench

//  Execute/writeback stage downstream of register_file: takes src1_dat/src2_dat plus decoded op,

---
 rtl/exec_unit_if.sv | 33 +++
 rtl/exec_unit.sv | 183 ++++++++++++++++++
 tb/tb_exec_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_if.sv
// ----------------------------------------------------------------------------
// exec_unit_if : decoder-to-execute bus and execute-to-register_file write port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface exec_unit_if #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [WIDTH-1:0]  src1_dat;
  logic [WIDTH-1:0]  src2_dat;
  logic [REG_AW-1:0] tgt_in;
  logic [REG_AW-1:0] tgt;
  logic [WIDTH-1:0]  tgt_dat;
  logic              out_valid;
  logic              illegal;

  modport master (
    output in_valid, op, src1_dat, src2_dat, tgt_in,
    input  in_ready, tgt, tgt_dat, out_valid, illegal
  );

  modport slave (
    input  in_valid, op, src1_dat, src2_dat, tgt_in,
    output in_ready, tgt, tgt_dat, out_valid, illegal
  );
endinterface

`default_nettype wire

// File: rtl/exec_unit.sv
// ----------------------------------------------------------------------------
// exec_unit : execute/writeback stage; single-cycle ALU ops, iterative shifts,
//             optional iterative MUL (enabled by defining EXEC_MUL_EN)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exec_unit #(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  exec_unit_if.slave bus
);

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1} state_t;
`endif

  localparam logic [3:0] c_op_add  = 4'd0;
  localparam logic [3:0] c_op_sub  = 4'd1;
  localparam logic [3:0] c_op_and  = 4'd2;
  localparam logic [3:0] c_op_or   = 4'd3;
  localparam logic [3:0] c_op_xor  = 4'd4;
  localparam logic [3:0] c_op_sll  = 4'd5;
  localparam logic [3:0] c_op_srl  = 4'd6;
  localparam logic [3:0] c_op_sra  = 4'd7;
  localparam logic [3:0] c_op_slt  = 4'd8;
  localparam logic [3:0] c_op_sltu = 4'd9;
`ifdef EXEC_MUL_EN
  localparam logic [3:0] c_op_mul  = 4'd10;
`endif

  state_t            r_state;
  logic [WIDTH-1:0]  r_a;
  logic [1:0]        r_sh_kind;
  logic [4:0]        r_cnt;
  logic [REG_AW-1:0] r_tgt_sav;
  logic [REG_AW-1:0] r_tgt;
  logic [WIDTH-1:0]  r_tgt_dat;
  logic              r_out_valid;
  logic              r_illegal;
`ifdef EXEC_MUL_EN
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_acc;
  logic [WIDTH-1:0]  w_acc_nxt;
`endif

  logic [WIDTH-1:0]  w_res;
  logic              w_ill;
  logic [3:0]        w_amt;
  logic              w_is_shift;
  logic              w_accept;
  logic [WIDTH-1:0]  w_shift_nxt;

  assign w_amt      = bus.src2_dat[3:0];
  assign w_is_shift = (bus.op == c_op_sll) || (bus.op == c_op_srl) || (bus.op == c_op_sra);
  assign w_accept   = bus.in_valid && (r_state == S_IDLE);

  // Single-cycle results; a shift by zero passes operand A through unchanged.
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (bus.op)
      c_op_add:  w_res = bus.src1_dat + bus.src2_dat;
      c_op_sub:  w_res = bus.src1_dat - bus.src2_dat;
      c_op_and:  w_res = bus.src1_dat & bus.src2_dat;
      c_op_or:   w_res = bus.src1_dat | bus.src2_dat;
      c_op_xor:  w_res = bus.src1_dat ^ bus.src2_dat;
      c_op_sll, c_op_srl, c_op_sra: w_res = bus.src1_dat;
      c_op_slt:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_dat) < $signed(bus.src2_dat))};
      c_op_sltu: w_res = {{(WIDTH-1){1'b0}}, (bus.src1_dat < bus.src2_dat)};
`ifdef EXEC_MUL_EN
      c_op_mul:  w_res = '0;
`endif
      default:   w_ill = 1'b1;
    endcase
  end

  // r_sh_kind holds op[1:0]: 01 SLL, 10 SRL, 11 SRA.
  always_comb begin
    w_shift_nxt = '0;
    case (r_sh_kind)
      2'b01:   w_shift_nxt = {r_a[WIDTH-2:0], 1'b0};
      2'b10:   w_shift_nxt = {1'b0, r_a[WIDTH-1:1]};
      default: w_shift_nxt = {r_a[WIDTH-1], r_a[WIDTH-1:1]};
    endcase
  end

`ifdef EXEC_MUL_EN
  assign w_acc_nxt = r_acc + (r_b[0] ? r_a : '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_sh_kind   <= '0;
      r_cnt       <= '0;
      r_tgt_sav   <= '0;
      r_tgt       <= '0;
      r_tgt_dat   <= '0;
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef EXEC_MUL_EN
      r_b         <= '0;
      r_acc       <= '0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      r_illegal   <= 1'b0;
      r_tgt       <= '0;
      r_tgt_dat   <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_shift && (w_amt != 4'd0)) begin
              r_a       <= bus.src1_dat;
              r_sh_kind <= bus.op[1:0];
              r_cnt     <= {1'b0, w_amt};
              r_tgt_sav <= bus.tgt_in;
              r_state   <= S_SHIFT;
            end
`ifdef EXEC_MUL_EN
            else if (bus.op == c_op_mul) begin
              r_a       <= bus.src1_dat;
              r_b       <= bus.src2_dat;
              r_acc     <= '0;
              r_cnt     <= 5'd16;
              r_tgt_sav <= bus.tgt_in;
              r_state   <= S_MUL;
            end
`endif
            else begin
              r_out_valid <= 1'b1;
              r_illegal   <= w_ill;
              r_tgt       <= w_ill ? '0 : bus.tgt_in;
              r_tgt_dat   <= w_ill ? '0 : w_res;
            end
          end
        end
        S_SHIFT: begin
          r_a   <= w_shift_nxt;
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_out_valid <= 1'b1;
            r_tgt       <= r_tgt_sav;
            r_tgt_dat   <= w_shift_nxt;
            r_state     <= S_IDLE;
          end
        end
`ifdef EXEC_MUL_EN
        // Shift-add: multiplicand moves left, multiplier right, one bit per cycle.
        S_MUL: begin
          r_acc <= w_acc_nxt;
          r_a   <= {r_a[WIDTH-2:0], 1'b0};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_out_valid <= 1'b1;
            r_tgt       <= r_tgt_sav;
            r_tgt_dat   <= w_acc_nxt;
            r_state     <= S_IDLE;
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.tgt       = r_tgt;
  assign bus.tgt_dat   = r_tgt_dat;
  assign bus.out_valid = r_out_valid;
  assign bus.illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// ----------------------------------------------------------------------------
// tb_exec_unit : randomized + directed checks of exec_unit against a latency/result model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_exec_unit;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  exec_unit_if u_if ();
  exec_unit u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if));

  int n_chk  = 0;
  int n_pass = 0;

  // Model: cycles still to wait for a pending multi-cycle result, plus expected outputs.
  int          m_wait;
  logic [15:0] m_pres;
  logic [2:0]  m_ptgt;
  logic        e_valid, e_ill;
  logic [2:0]  e_tgt;
  logic [15:0] e_dat;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic void predict(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] res, output logic ill, output int lat);
    logic [31:0] p;
    res = '0; ill = 1'b0; lat = 0;
    case (op)
      4'd0: res = a + b;
      4'd1: res = a - b;
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: begin lat = int'(b[3:0]); res = a << b[3:0]; end
      4'd6: begin lat = int'(b[3:0]); res = a >> b[3:0]; end
      4'd7: begin lat = int'(b[3:0]); res = $signed(a) >>> b[3:0]; end
      4'd8: res = {15'd0, ($signed(a) < $signed(b))};
      4'd9: res = {15'd0, (a < b)};
`ifdef EXEC_MUL_EN
      4'd10: begin p = {16'd0, a} * {16'd0, b}; res = p[15:0]; lat = 16; end
`endif
      default: ill = 1'b1;
    endcase
  endfunction

  task automatic model_clear();
    m_wait = 0; m_pres = '0; m_ptgt = '0;
    e_valid = 1'b0; e_ill = 1'b0; e_tgt = '0; e_dat = '0;
  endtask

  task automatic model_update();
    logic [15:0] res;
    logic        ill;
    int          lat;
    e_valid = 1'b0; e_ill = 1'b0; e_tgt = '0; e_dat = '0;
    if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin e_valid = 1'b1; e_tgt = m_ptgt; e_dat = m_pres; end
    end else if (u_if.in_valid) begin
      predict(u_if.op, u_if.src1_dat, u_if.src2_dat, res, ill, lat);
      if (ill) begin
        e_valid = 1'b1; e_ill = 1'b1;
      end else if (lat == 0) begin
        e_valid = 1'b1; e_tgt = u_if.tgt_in; e_dat = res;
      end else begin
        m_wait = lat; m_pres = res; m_ptgt = u_if.tgt_in;
      end
    end
  endtask

  task automatic compare();
    check("in_ready",  {31'd0, u_if.in_ready},  {31'd0, (m_wait == 0)});
    check("out_valid", {31'd0, u_if.out_valid}, {31'd0, e_valid});
    check("illegal",   {31'd0, u_if.illegal},   {31'd0, e_ill});
    check("tgt",       {29'd0, u_if.tgt},       {29'd0, e_tgt});
    check("tgt_dat",   {16'd0, u_if.tgt_dat},   {16'd0, e_dat});
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic [15:0] a,
                      input logic [15:0] b, input logic [2:0] t);
    u_if.in_valid = v; u_if.op = op; u_if.src1_dat = a; u_if.src2_dat = b; u_if.tgt_in = t;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 16'd0, 16'd0, 3'd0);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    u_if.in_valid = 1'b1; u_if.op = 4'd0; u_if.src1_dat = 16'h1111;
    u_if.src2_dat = 16'h2222; u_if.tgt_in = 3'd5;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, u_if.out_valid}, 32'd0);
    check("rst_tgt",       {29'd0, u_if.tgt},       32'd0);
    check("rst_tgt_dat",   {16'd0, u_if.tgt_dat},   32'd0);
    check("rst_illegal",   {31'd0, u_if.illegal},   32'd0);
    u_if.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  {31'd0, u_if.in_ready},  32'd1);
    @(negedge clk);

    step(1'b1, 4'd0, 16'h7FFF, 16'h0001, 3'd3);
    check("add_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("add_dat",   {16'd0, u_if.tgt_dat},   32'h8000);
    check("add_tgt",   {29'd0, u_if.tgt},       32'd3);
    step(1'b1, 4'd1, 16'h0000, 16'h0001, 3'd4);
    check("sub_dat",   {16'd0, u_if.tgt_dat},   32'hFFFF);
    check("sub_tgt",   {29'd0, u_if.tgt},       32'd4);

    step(1'b1, 4'd7, 16'h8000, 16'h0013, 3'd5);
    check("sra_busy1", {31'd0, u_if.in_ready},  32'd0);
    step(1'b1, 4'd0, 16'h0001, 16'h0001, 3'd1);
    check("sra_busy2", {31'd0, u_if.in_ready},  32'd0);
    idle(1);
    check("sra_busy3", {31'd0, u_if.in_ready},  32'd0);
    check("sra_early", {31'd0, u_if.out_valid}, 32'd0);
    idle(1);
    check("sra_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("sra_dat",   {16'd0, u_if.tgt_dat},   32'hF000);
    check("sra_tgt",   {29'd0, u_if.tgt},       32'd5);

    step(1'b1, 4'd5, 16'h1234, 16'h0010, 3'd2);
    check("sll0_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("sll0_dat",   {16'd0, u_if.tgt_dat},   32'h1234);

    step(1'b1, 4'd8, 16'hFFFF, 16'h0001, 3'd1);
    check("slt_dat",  {16'd0, u_if.tgt_dat}, 32'd1);
    step(1'b1, 4'd9, 16'hFFFF, 16'h0001, 3'd1);
    check("sltu_dat", {16'd0, u_if.tgt_dat}, 32'd0);
    check("sltu_tgt", {29'd0, u_if.tgt},     32'd1);
    step(1'b1, 4'd15, 16'h1234, 16'h5678, 3'd6);
    check("op15_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("op15_ill",   {31'd0, u_if.illegal},   32'd1);
    check("op15_tgt",   {29'd0, u_if.tgt},       32'd0);

    step(1'b1, 4'd0, 16'h0005, 16'h0006, 3'd0);
    check("r0_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("r0_tgt",   {29'd0, u_if.tgt},       32'd0);

`ifdef EXEC_MUL_EN
    step(1'b1, 4'd10, 16'h0123, 16'h0456, 3'd7);
    idle(15);
    check("mul_early", {31'd0, u_if.out_valid}, 32'd0);
    idle(1);
    check("mul_valid", {31'd0, u_if.out_valid}, 32'd1);
    check("mul_dat",   {16'd0, u_if.tgt_dat},   32'hEDC2);
    check("mul_tgt",   {29'd0, u_if.tgt},       32'd7);
    step(1'b1, 4'd10, 16'hFFFF, 16'hFFFF, 3'd2);
    idle(16);
    check("mulff_dat", {16'd0, u_if.tgt_dat},   32'h0001);

    step(1'b1, 4'd10, 16'h00FF, 16'h0101, 3'd3);
    idle(4);
    rst_n = 1'b0;
    model_clear();
    #1;
    check("mulrst_valid", {31'd0, u_if.out_valid}, 32'd0);
    check("mulrst_ready", {31'd0, u_if.in_ready},  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle(20);
`else
    step(1'b1, 4'd10, 16'h0123, 16'h0456, 3'd7);
    check("mul_ill",   {31'd0, u_if.illegal},   32'd1);
    check("mul_tgt",   {29'd0, u_if.tgt},       32'd0);
    check("mul_dat",   {16'd0, u_if.tgt_dat},   32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [15:0] b;
      b = 16'($urandom);
      if ($urandom_range(0, 2) == 0) b[3:0] = 4'($urandom_range(0, 3));
      step(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 16'($urandom), b,
           3'($urandom_range(0, 7)));
    end
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire
